count_order_monitor: RTL and testbench



---
 rtl/count_mon_pkg.sv | 15 +
 rtl/count_step_cmp.sv | 24 ++
 rtl/count_order_monitor.sv | 163 ++++++++++++++++
 tb/tb_count_order_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count order monitor.
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQ     = 2'd1,
    LOCK_UP = 2'd2,
    LOCK_DN = 2'd3
  } state_t;

  localparam int               ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;
  localparam int               MISS_W      = 4;

endpackage

// File: rtl/count_step_cmp.sv
// Classifies one count step: is the new sample prev+1 / prev-1, and does that step cross the wrap boundary.
module count_step_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_s,
  output logic             o_is_next,
  output logic             o_is_prev,
  output logic             o_is_wrap_up,
  output logic             o_is_wrap_dn
);

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_prev;

  assign w_next       = i_prev + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_prev       = i_prev - {{(WIDTH-1){1'b0}}, 1'b1};
  assign o_is_next    = (i_s == w_next);
  assign o_is_prev    = (i_s == w_prev);
  // Wrap flags describe the step prev->s, independent of which direction is locked.
  assign o_is_wrap_up = o_is_next && (i_prev == {WIDTH{1'b1}});
  assign o_is_wrap_dn = o_is_prev && (i_prev == {WIDTH{1'b0}});

endmodule

// File: rtl/count_order_monitor.sv
// Locks onto the direction of a wrap-around count stream and flags wraps, reversals and ordering errors.
// Optional feature macro: COUNT_MON_REV_EN (accept a single-step direction reversal while locked).
module count_order_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  // in_valid qualifies in_count for exactly one cycle; there is no backpressure.
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  output logic                 locked,
  output logic                 dir,
  output logic                 wrap,
  output logic                 rev,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output state_t               dbg_state
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_prev;
  logic [MISS_W-1:0]    r_miss;
  logic [MISS_W-1:0]    w_miss_nxt;
  logic [MISS_W:0]      w_miss_inc;
  logic                 r_dir;
  logic                 w_dir_nxt;
  logic                 r_locked;
  logic                 r_wrap;
  logic                 r_rev;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_wrap;
  logic                 w_rev;
  logic                 w_err;
  logic                 w_is_next;
  logic                 w_is_prev;
  logic                 w_is_wrap_up;
  logic                 w_is_wrap_dn;

  count_step_cmp #(.WIDTH(WIDTH)) u_cmp (
    .i_prev       (r_prev),
    .i_s          (in_count),
    .o_is_next    (w_is_next),
    .o_is_prev    (w_is_prev),
    .o_is_wrap_up (w_is_wrap_up),
    .o_is_wrap_dn (w_is_wrap_dn)
  );

  assign w_miss_inc = {1'b0, r_miss} + {{MISS_W{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_dir_nxt   = r_dir;
    w_wrap      = 1'b0;
    w_rev       = 1'b0;
    w_err       = 1'b0;
    if (in_valid) begin
      case (r_state)
        IDLE: w_state_nxt = ACQ;
        ACQ: begin
          // Up is tested first so that WIDTH=1 (next==prev) resolves to up.
          if (w_is_next) begin
            w_state_nxt = LOCK_UP;
            w_dir_nxt   = 1'b1;
            w_miss_nxt  = '0;
          end else if (w_is_prev) begin
            w_state_nxt = LOCK_DN;
            w_dir_nxt   = 1'b0;
            w_miss_nxt  = '0;
          end
        end
        LOCK_UP: begin
          if (w_is_next) begin
            w_miss_nxt = '0;
            w_wrap     = w_is_wrap_up;
          end else if (w_is_prev) begin
`ifdef COUNT_MON_REV_EN
            w_state_nxt = LOCK_DN;
            w_dir_nxt   = 1'b0;
            w_rev       = 1'b1;
            w_miss_nxt  = '0;
            w_wrap      = w_is_wrap_dn;
`else
            w_err = 1'b1;
`endif
          end else begin
            w_err = 1'b1;
          end
        end
        LOCK_DN: begin
          if (w_is_prev) begin
            w_miss_nxt = '0;
            w_wrap     = w_is_wrap_dn;
          end else if (w_is_next) begin
`ifdef COUNT_MON_REV_EN
            w_state_nxt = LOCK_UP;
            w_dir_nxt   = 1'b1;
            w_rev       = 1'b1;
            w_miss_nxt  = '0;
            w_wrap      = w_is_wrap_up;
`else
            w_err = 1'b1;
`endif
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      // A violation that reaches the limit drops lock and clears the miss run together.
      if (w_err) begin
        if (int'(w_miss_inc) >= ERR_LIMIT) begin
          w_state_nxt = ACQ;
          w_miss_nxt  = '0;
        end else begin
          w_miss_nxt = w_miss_inc[MISS_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_prev    <= '0;
      r_miss    <= '0;
      r_dir     <= 1'b1;
      r_locked  <= 1'b0;
      r_wrap    <= 1'b0;
      r_rev     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_wrap <= w_wrap;
      r_rev  <= w_rev;
      r_err  <= w_err;
      if (in_valid) begin
        r_state  <= w_state_nxt;
        r_prev   <= in_count;
        r_miss   <= w_miss_nxt;
        r_dir    <= w_dir_nxt;
        r_locked <= (w_state_nxt == LOCK_UP) || (w_state_nxt == LOCK_DN);
        if (w_err && (r_err_cnt != ERR_CNT_MAX)) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign locked    = r_locked;
  assign dir       = r_dir;
  assign wrap      = r_wrap;
  assign rev       = r_rev;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_count_order_monitor.sv
// Randomized and directed bench for count_order_monitor against a step-delta reference model.
module tb_count_order_monitor;
  import count_mon_pkg::*;

  localparam int W    = 4;
  localparam int LIM  = 3;
  localparam int MASK = (1 << W) - 1;
`ifdef COUNT_MON_REV_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_count;
  logic         locked;
  logic         dir;
  logic         wrap;
  logic         rev;
  logic         err;
  logic [7:0]   err_cnt;
  state_t       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {locked, dir, wrap, rev, err, err_cnt[7:0]} per clock.
  logic [12:0] exp_q[$];

  // Reference model: direction as +1/-1 step modulo 2^W.
  bit m_seen;
  bit m_lock;
  bit m_up;
  int m_prev;
  int m_miss;
  int m_errs;

  count_order_monitor #(.WIDTH(W), .ERR_LIMIT(LIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .locked    (locked),
    .dir       (dir),
    .wrap      (wrap),
    .rev       (rev),
    .err       (err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_lock = 0; m_up = 1; m_prev = 0; m_miss = 0; m_errs = 0;
  endtask

  task automatic push_exp(input bit e_wrap, input bit e_rev, input bit e_err);
    exp_q.push_back({m_lock, m_up, e_wrap, e_rev, e_err, 8'(m_errs)});
  endtask

  task automatic model_sample(input int s);
    int d;
    bit e_wrap, e_rev, e_err;
    e_wrap = 0; e_rev = 0; e_err = 0;
    d = (s - m_prev) & MASK;
    if (!m_seen) begin
      m_seen = 1;
    end else if (!m_lock) begin
      if (d == 1)         begin m_lock = 1; m_up = 1; m_miss = 0; end
      else if (d == MASK) begin m_lock = 1; m_up = 0; m_miss = 0; end
    end else if (d == (m_up ? 1 : MASK)) begin
      m_miss = 0;
      e_wrap = (m_up && s == 0) || (!m_up && s == MASK);
    end else if (REV_EN && d == (m_up ? MASK : 1)) begin
      e_rev  = 1;
      e_wrap = (m_prev == 0 && s == MASK) || (m_prev == MASK && s == 0);
      m_up   = !m_up;
      m_miss = 0;
    end else begin
      e_err  = 1;
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
      m_miss++;
      if (m_miss >= LIM) begin m_lock = 0; m_miss = 0; end
    end
    m_prev = s;
    push_exp(e_wrap, e_rev, e_err);
  endtask

  task automatic compare_outputs();
    logic [12:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("locked",  int'(locked),  int'(e[12]));
    check_eq("dir",     int'(dir),     int'(e[11]));
    check_eq("wrap",    int'(wrap),    int'(e[10]));
    check_eq("rev",     int'(rev),     int'(e[9]));
    check_eq("err",     int'(err),     int'(e[8]));
    check_eq("err_cnt", int'(err_cnt), int'(e[7:0]));
  endtask

  task automatic drive(input bit v, input int s);
    in_valid = v;
    in_count = W'(s);
    @(posedge clk);
    #1;
    if (v) model_sample(s & MASK);
    else   push_exp(1'b0, 1'b0, 1'b0);
    compare_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_locked"},  int'(locked),  0);
    check_eq({tag, "_dir"},     int'(dir),     1);
    check_eq({tag, "_wrap"},    int'(wrap),    0);
    check_eq({tag, "_rev"},     int'(rev),     0);
    check_eq({tag, "_err"},     int'(err),     0);
    check_eq({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #2;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b0;

    // Up count through a full wrap.
    for (int i = 0; i < 18; i++) drive(1, i);
    check_eq("up_err_cnt", int'(err_cnt), 0);
    check_eq("up_dir", int'(dir), 1);

    // Down count through a full wrap.
    do_reset();
    for (int i = 0; i < 17; i++) drive(1, MASK - i);
    check_eq("dn_dir", int'(dir), 0);

    // Lock up at 5, skip, then a run of three bad samples drops lock.
    do_reset();
    drive(1, 4); drive(1, 5); drive(1, 7);
    check_eq("skip_err_cnt", int'(err_cnt), 1);
    check_eq("skip_locked", int'(locked), 1);
    drive(1, 8); drive(1, 8); drive(1, 8); drive(1, 8);
    check_eq("drop_err_cnt", int'(err_cnt), 4);
    check_eq("drop_locked", int'(locked), 0);

    // Reversal from up lock at 6, and across the boundary.
    do_reset();
    drive(1, 5); drive(1, 6); drive(1, 5); drive(1, 4);
    do_reset();
    drive(1, MASK); drive(1, 0); drive(1, MASK);

    // Gapped valid samples must match a contiguous stream.
    do_reset();
    drive(1, 0); drive(0, $urandom_range(0, MASK)); drive(1, 1);
    drive(0, $urandom_range(0, MASK)); drive(1, 2); drive(0, 9);
    check_eq("gap_locked", int'(locked), 1);

    // Saturate err_cnt by repeatedly locking then failing.
    do_reset();
    drive(1, 0);
    for (int k = 0; k < 110; k++) begin
      drive(1, (k + 1) & MASK);
      for (int j = 0; j < LIM; j++) drive(1, (k + 1) & MASK);
    end
    check_eq("sat_err_cnt", int'(err_cnt), 255);

    // Randomized stream biased toward legal steps.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int sel, s;
      sel = $urandom_range(0, 9);
      if (sel < 5)       s = m_prev + (m_up ? 1 : -1);
      else if (sel < 7)  s = m_prev + (m_up ? -1 : 1);
      else if (sel < 8)  s = m_prev;
      else               s = $urandom_range(0, MASK);
      drive($urandom_range(0, 3) != 0, s & MASK);
      if (n == 300) begin
        // Asynchronous reset mid-stream, checked before the next clock edge.
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
      end
    end

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
